// File: rtl/dragonfang_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dragonfang_pkg : shared datapath types for the vector back end       |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
package dragonfang_pkg;
    import riscv_v_pkg::*;

    typedef struct packed {
        logic [VLEN-1:0]  data;
        logic [4:0]       address;
        logic [VLENB-1:0] byte_enable;
    } writeback_entry_t;

endpackage
`default_nettype wire

// File: rtl/riscv_v_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_v_pkg : vector ISA constants (VLEN) and SEW encoding           |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package riscv_v_pkg;

    localparam int VLEN  = 128;
    localparam int VLENB = VLEN / 8;
    localparam int VL_W  = $clog2(VLENB) + 1;

    typedef enum logic [1:0] {
        SEW_8  = 2'd0,
        SEW_16 = 2'd1,
        SEW_32 = 2'd2,
        SEW_64 = 2'd3
    } sew_e;

    // Number of elements of the given width that fit in one vector register.
    function automatic logic [VL_W-1:0] elems_per_reg(input sew_e s);
        return VL_W'(VLENB >> s);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vector_byte_enable_generator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vector_byte_enable_generator : per-byte write enables from sew/vl/v0 |
// | Revision                     : 1.0                                   |
// +----------------------------------------------------------------------+
module vector_byte_enable_generator
    import riscv_v_pkg::*;
(
    input  logic [1:0]       sew,
    input  logic [VL_W-1:0]  vl,
    input  logic             vm,
    input  logic [VLENB-1:0] v0_mask,
    output logic [VLENB-1:0] byte_enable
);

    logic [VL_W-1:0] max_elems;
    logic [VL_W-1:0] vl_eff;
    logic [VL_W-1:0] elem;

    always_comb begin
        byte_enable = '0;
        elem        = '0;
        max_elems   = elems_per_reg(sew_e'(sew));
        vl_eff      = (vl > max_elems) ? max_elems : vl;
        // Byte j belongs to element j >> sew; tail and masked-off bytes stay disabled.
        for (int j = 0; j < VLENB; j++) begin
            elem           = VL_W'(j) >> sew;
            byte_enable[j] = (elem < vl_eff) && (vm || v0_mask[elem[VL_W-2:0]]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/vector_result_writeback_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vector_result_writeback_unit : result FIFO feeding the VRF write port|
// | Revision                     : 1.0                                   |
// +----------------------------------------------------------------------+
module vector_result_writeback_unit
    import riscv_v_pkg::*;
    import dragonfang_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             result_valid,
    output logic             result_ready,
    input  logic [VLEN-1:0]  vd,
    input  logic [4:0]       vd_address,
    input  logic [1:0]       sew,
    input  logic [VL_W-1:0]  vl,
    input  logic             vm,
    input  logic [VLENB-1:0] v0_mask,
    output logic             vrf_write_enable,
    input  logic             vrf_write_ready,
    output logic [4:0]       vrf_write_address,
    output logic [VLEN-1:0]  vrf_write_data,
    output logic [VLENB-1:0] vrf_byte_enable,
    output logic             writeback_done,
    output logic [4:0]       writeback_done_address
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    writeback_entry_t entries_q [DEPTH];
    writeback_entry_t head;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [VLENB-1:0] push_byte_enable;
    logic             head_valid;
    logic             push;
    logic             pop;

    vector_byte_enable_generator u_byte_enable_generator (
        .sew         (sew),
        .vl          (vl),
        .vm          (vm),
        .v0_mask     (v0_mask),
        .byte_enable (push_byte_enable)
    );

    always_comb begin
        head_valid   = (count_q != '0);
        head         = entries_q[rd_ptr_q];
        result_ready = (count_q < CNT_W'(DEPTH));
        push         = result_valid && result_ready;
        // An entry with no active bytes retires without occupying the VRF port.
        pop          = head_valid && (vrf_write_ready || (head.byte_enable == '0));

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

        vrf_write_enable       = head_valid && (head.byte_enable != '0);
        vrf_write_address      = head_valid ? head.address     : '0;
        vrf_write_data         = head_valid ? head.data        : '0;
        vrf_byte_enable        = head_valid ? head.byte_enable : '0;
        writeback_done         = pop;
        writeback_done_address = head_valid ? head.address     : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            entries_q[wr_ptr_q] <= '{data: vd, address: vd_address, byte_enable: push_byte_enable};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vector_result_writeback_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vector_result_writeback_unit : queue model + directed/random bench|
// | Revision                        : 1.0                                |
// +----------------------------------------------------------------------+
module tb_vector_result_writeback_unit;

    localparam int DEPTH = 2;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         result_valid;
    logic         result_ready;
    logic [127:0] vd;
    logic [4:0]   vd_address;
    logic [1:0]   sew;
    logic [4:0]   vl;
    logic         vm;
    logic [15:0]  v0_mask;
    logic         vrf_write_enable;
    logic         vrf_write_ready;
    logic [4:0]   vrf_write_address;
    logic [127:0] vrf_write_data;
    logic [15:0]  vrf_byte_enable;
    logic         writeback_done;
    logic [4:0]   writeback_done_address;

    vector_result_writeback_unit #(.DEPTH(DEPTH)) dut (
        .clock                  (clock),
        .reset_n                (reset_n),
        .result_valid           (result_valid),
        .result_ready           (result_ready),
        .vd                     (vd),
        .vd_address             (vd_address),
        .sew                    (sew),
        .vl                     (vl),
        .vm                     (vm),
        .v0_mask                (v0_mask),
        .vrf_write_enable       (vrf_write_enable),
        .vrf_write_ready        (vrf_write_ready),
        .vrf_write_address      (vrf_write_address),
        .vrf_write_data         (vrf_write_data),
        .vrf_byte_enable        (vrf_byte_enable),
        .writeback_done         (writeback_done),
        .writeback_done_address (writeback_done_address)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [127:0] data;
        logic [4:0]   addr;
        logic [15:0]  be;
    } ent_t;

    ent_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   retired  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Element-wise view: count active elements, then enable each one's bytes.
    function automatic logic [15:0] model_be(input logic [1:0] s, input logic [4:0] l,
                                             input logic m, input logic [15:0] mk);
        int bytes_per = 1 << s;
        int n_elem    = 16 / bytes_per;
        int lim       = (int'(l) > n_elem) ? n_elem : int'(l);
        logic [15:0] r = '0;
        for (int e = 0; e < lim; e++)
            if (m || mk[e])
                for (int b = 0; b < bytes_per; b++)
                    r[e * bytes_per + b] = 1'b1;
        return r;
    endfunction

    always @(negedge clock) begin
        if (!reset_n) begin
            q.delete();
            chk("rst_ready", result_ready, 1);
            chk("rst_we", vrf_write_enable, 0);
            chk("rst_done", writeback_done, 0);
            chk("rst_addr", vrf_write_address, 0);
            chk("rst_data", vrf_write_data, 0);
            chk("rst_be", vrf_byte_enable, 0);
            chk("rst_done_addr", writeback_done_address, 0);
        end else begin
            automatic bit   exp_ready = (q.size() < DEPTH);
            automatic bit   exp_done  = 1'b0;
            automatic ent_t e;
            chk("ready", result_ready, exp_ready);
            if (q.size() > 0) begin
                e        = q[0];
                exp_done = vrf_write_ready || (e.be == 16'h0);
                chk("we", vrf_write_enable, e.be != 16'h0);
                chk("addr", vrf_write_address, e.addr);
                chk("data", vrf_write_data, e.data);
                chk("be", vrf_byte_enable, e.be);
                chk("done", writeback_done, exp_done);
                if (exp_done) chk("done_addr", writeback_done_address, e.addr);
            end else begin
                chk("idle_we", vrf_write_enable, 0);
                chk("idle_data", vrf_write_data, 0);
                chk("idle_be", vrf_byte_enable, 0);
                chk("idle_done", writeback_done, 0);
            end
            if (exp_done) begin
                void'(q.pop_front());
                retired++;
            end
            if (result_valid && exp_ready) begin
                e.data = vd;
                e.addr = vd_address;
                e.be   = model_be(sew, vl, vm, v0_mask);
                q.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit v, input logic [127:0] d, input logic [4:0] a,
                         input logic [1:0] s, input logic [4:0] l, input bit m,
                         input logic [15:0] mk);
        result_valid = v;
        vd           = d;
        vd_address   = a;
        sew          = s;
        vl           = l;
        vm           = m;
        v0_mask      = mk;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int base;
        reset_n         = 1'b0;
        vrf_write_ready = 1'b1;
        drive(0, '0, '0, '0, '0, 1'b1, '0);
        repeat (3) step();
        chk("lit_rst_ready", result_ready, 1);
        chk("lit_rst_we", vrf_write_enable, 0);
        reset_n = 1'b1;
        step();

        // 64-bit elements, vl=2 fills the register
        drive(1, 128'h0123456789ABCDEF_0123456789ABCDEF, 5'd5, 2'd3, 5'd2, 1'b1, 16'h0);
        step();
        result_valid = 1'b0;
        #1;
        chk("lit33_we", vrf_write_enable, 1);
        chk("lit33_addr", vrf_write_address, 5);
        chk("lit33_be", vrf_byte_enable, 16'hFFFF);
        chk("lit33_done", writeback_done, 1);
        chk("lit33_data", vrf_write_data, 128'h0123456789ABCDEF_0123456789ABCDEF);
        step();

        drive(1, rnd128(), 5'd7, 2'd2, 5'd3, 1'b0, 16'h0005);
        step();
        result_valid = 1'b0;
        #1;
        chk("lit34_be", vrf_byte_enable, 16'h0F0F);
        step();

        drive(1, rnd128(), 5'd9, 2'd0, 5'd0, 1'b1, 16'h0);
        step();
        result_valid = 1'b0;
        #1;
        chk("lit35_we", vrf_write_enable, 0);
        chk("lit35_done", writeback_done, 1);
        chk("lit35_done_addr", writeback_done_address, 9);
        step();

        vrf_write_ready = 1'b0;
        drive(1, 128'hAAAA, 5'd1, 2'd0, 5'd16, 1'b1, 16'h0);
        step();
        drive(1, 128'hBBBB, 5'd2, 2'd0, 5'd16, 1'b1, 16'h0);
        step();
        drive(1, 128'hCCCC, 5'd3, 2'd0, 5'd16, 1'b1, 16'h0);
        #1;
        chk("lit36_full", result_ready, 0);
        chk("lit36_data0", vrf_write_data, 128'hAAAA);
        result_valid = 1'b0;
        step();
        step();
        #1;
        chk("lit36_hold", vrf_write_data, 128'hAAAA);
        chk("lit36_hold_addr", vrf_write_address, 1);
        chk("lit36_nodone", writeback_done, 0);
        vrf_write_ready = 1'b1;
        #1;
        chk("lit36_ret1", writeback_done_address, 1);
        step();
        #1;
        chk("lit36_ret2", writeback_done_address, 2);
        chk("lit36_ret2_done", writeback_done, 1);
        step();

        vrf_write_ready = 1'b0;
        drive(1, rnd128(), 5'd20, 2'd1, 5'd8, 1'b1, 16'h0);
        step();
        drive(1, rnd128(), 5'd21, 2'd1, 5'd8, 1'b1, 16'h0);
        step();
        result_valid = 1'b0;
        step();
        #1;
        chk("lit37_we_before", vrf_write_enable, 1);
        reset_n = 1'b0;
        #1;
        chk("lit37_we_async", vrf_write_enable, 0);
        chk("lit37_ready_async", result_ready, 1);
        step();
        step();
        reset_n         = 1'b1;
        vrf_write_ready = 1'b1;
        base            = retired;
        repeat (3) begin
            step();
            #1;
            chk("lit37_no_done", writeback_done, 0);
        end
        chk("lit37_no_retire", retired, base);

        base = retired;
        for (int i = 0; i < 10; i++) begin
            drive(1, rnd128(), 5'(10 + i), 2'($urandom_range(0, 3)), 5'd16, 1'b1, 16'h0);
            step();
            #1;
            chk("lit38_ready", result_ready, 1);
        end
        result_valid = 1'b0;
        step();
        step();
        chk("lit38_count", retired - base, 10);

        repeat (400) begin
            drive($urandom_range(0, 1), rnd128(), 5'($urandom_range(0, 31)),
                  2'($urandom_range(0, 3)), 5'($urandom_range(0, 20)),
                  1'($urandom_range(0, 1)), 16'($urandom));
            vrf_write_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        result_valid    = 1'b0;
        vrf_write_ready = 1'b1;
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
